// File: rtl/bus_latch_arbiter.sv
// Round-robin arbiter that sequences LE/OE_n of NREQ latch drivers sharing one bus.
// Each grant runs LATCH -> DRIVE -> TURN with all outputs taken straight from flops.
module bus_latch_arbiter #(
  parameter int NREQ         = 4,
  parameter int DRIVE_CYCLES = 2,
  parameter int TURN_CYCLES  = 1
) (
  input  logic                    sysclk,
  input  logic                    sys_rst,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         le,
  output logic [NREQ-1:0]         oe_n,
  output logic [NREQ-1:0]         done,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy
);
  localparam int IW   = $clog2(NREQ);
  localparam int MAXC = (DRIVE_CYCLES > TURN_CYCLES) ? DRIVE_CYCLES : TURN_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, LATCH, DRIVE, TURN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [NREQ-1:0] gnt_q, gnt_d, le_q, le_d, oe_n_q, oe_n_d, done_q, done_d;
  logic            busy_q, busy_d;

  logic [IW-1:0]   pick;
  logic [IW:0]     scan;
  logic            found;
  logic [NREQ-1:0] sel_d;

  // Rotating scan starting at rr_q; first requester found wins.
  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    scan  = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan = (IW+1)'(rr_q) + (IW+1)'(i);
      if (scan >= (IW+1)'(NREQ)) scan = scan - (IW+1)'(NREQ);
      if (!found && req[scan[IW-1:0]]) begin
        found = 1'b1;
        pick  = scan[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: if (found) begin
        owner_d = pick;
        state_d = LATCH;
      end
      LATCH: begin
        state_d = DRIVE;
        cnt_d   = CW'(DRIVE_CYCLES);
      end
      DRIVE: begin
        if (cnt_q == CW'(1)) begin
          rr_d = (owner_q == IW'(NREQ-1)) ? '0 : owner_q + IW'(1);
          if (TURN_CYCLES > 0) begin
            state_d = TURN;
            cnt_d   = CW'(TURN_CYCLES);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        if (cnt_q == CW'(1)) state_d = IDLE;
        else cnt_d = cnt_q - CW'(1);
      end
    endcase
  end

  // Outputs are computed from next state so they can be registered with no extra lag.
  always_comb begin
    sel_d  = {{(NREQ-1){1'b0}}, 1'b1} << owner_d;
    le_d   = (state_d == LATCH) ? sel_d : '0;
    gnt_d  = (state_d == LATCH || state_d == DRIVE) ? sel_d : '0;
    oe_n_d = (state_d == DRIVE) ? ~sel_d : '1;
    done_d = (state_d == DRIVE && cnt_d == CW'(1)) ? sel_d : '0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      gnt_q   <= '0;
      le_q    <= '0;
      oe_n_q  <= '1;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      le_q    <= le_d;
      oe_n_q  <= oe_n_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt   = gnt_q;
  assign le    = le_q;
  assign oe_n  = oe_n_q;
  assign done  = done_q;
  assign owner = owner_q;
  assign busy  = busy_q;
endmodule

// File: tb/tb_bus_latch_arbiter.sv
// Directed bench for bus_latch_arbiter plus a random soak over three D/T configurations.
// Instance 0 is (D=2,T=1); instances 1 and 2 are (1,0) and (3,2).
module tb_bus_latch_arbiter;
  logic       sysclk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [3:0] req_x  [3];
  logic [3:0] gnt_x  [3];
  logic [3:0] le_x   [3];
  logic [3:0] oe_x   [3];
  logic [3:0] done_x [3];
  logic [1:0] owner_x[3];
  logic       busy_x [3];

  int checks = 0;
  int errors = 0;
  int wt [3][4];
  int bnd [3] = '{20, 12, 28};

  always #5 sysclk = ~sysclk;

  bus_latch_arbiter #(.NREQ(4), .DRIVE_CYCLES(2), .TURN_CYCLES(1)) dut (
    .sysclk(sysclk), .sys_rst(sys_rst), .req(req_x[0]), .gnt(gnt_x[0]), .le(le_x[0]),
    .oe_n(oe_x[0]), .done(done_x[0]), .owner(owner_x[0]), .busy(busy_x[0]));
  bus_latch_arbiter #(.NREQ(4), .DRIVE_CYCLES(1), .TURN_CYCLES(0)) dut_a (
    .sysclk(sysclk), .sys_rst(sys_rst), .req(req_x[1]), .gnt(gnt_x[1]), .le(le_x[1]),
    .oe_n(oe_x[1]), .done(done_x[1]), .owner(owner_x[1]), .busy(busy_x[1]));
  bus_latch_arbiter #(.NREQ(4), .DRIVE_CYCLES(3), .TURN_CYCLES(2)) dut_b (
    .sysclk(sysclk), .sys_rst(sys_rst), .req(req_x[2]), .gnt(gnt_x[2]), .le(le_x[2]),
    .oe_n(oe_x[2]), .done(done_x[2]), .owner(owner_x[2]), .busy(busy_x[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] l,
                         input logic [3:0] o, input logic [3:0] d, input logic b);
    chk({tag, ".gnt"},  32'(gnt_x[0]),  32'(g));
    chk({tag, ".le"},   32'(le_x[0]),   32'(l));
    chk({tag, ".oe_n"}, 32'(oe_x[0]),   32'(o));
    chk({tag, ".done"}, 32'(done_x[0]), 32'(d));
    chk({tag, ".busy"}, 32'(busy_x[0]), 32'(b));
  endtask

  task automatic chk_inv(input int k);
    logic [3:0] drv;
    drv = ~oe_x[k];
    chk("inv.one_driver", 32'($countones(drv) <= 1), 1);
    chk("inv.le_vs_oe",   32'(le_x[k] & drv), 0);
    chk("inv.gnt_onehot", 32'($onehot0(gnt_x[k])), 1);
    chk("inv.le_onehot",  32'($onehot0(le_x[k])), 1);
    chk("inv.done_onehot", 32'($onehot0(done_x[k])), 1);
    chk("inv.done_driving", 32'(done_x[k] & oe_x[k]), 0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) req_x[k] = 4'h0;
    for (int k = 0; k < 3; k++) for (int i = 0; i < 4; i++) wt[k][i] = 0;

    // Reset with random requests pending
    req_x[0] = 4'($urandom_range(1, 15));
    tick(2);
    chk_out("rst", 4'h0, 4'h0, 4'hF, 4'h0, 1'b0);
    chk("rst.owner", 32'(owner_x[0]), 0);
    req_x[0] = 4'h0;
    sys_rst  = 1'b0;
    tick(2);
    chk_out("idle", 4'h0, 4'h0, 4'hF, 4'h0, 1'b0);

    // Single grant to requester 1
    req_x[0] = 4'b0010;
    tick;
    req_x[0] = 4'h0;
    chk_out("g1.c1", 4'b0010, 4'b0010, 4'hF, 4'h0, 1'b1);
    chk("g1.owner", 32'(owner_x[0]), 1);
    tick;
    chk_out("g1.c2", 4'b0010, 4'h0, 4'b1101, 4'h0, 1'b1);
    tick;
    chk_out("g1.c3", 4'b0010, 4'h0, 4'b1101, 4'b0010, 1'b1);
    tick;
    chk_out("g1.c4", 4'h0, 4'h0, 4'hF, 4'h0, 1'b1);
    tick;
    chk_out("g1.c5", 4'h0, 4'h0, 4'hF, 4'h0, 1'b0);
    chk("g1.owner_hold", 32'(owner_x[0]), 1);

    // All requesting: strict rotation 0,1,2,3,0,... one grant every 5 cycles
    sys_rst = 1'b1;
    tick;
    sys_rst  = 1'b0;
    req_x[0] = 4'hF;
    for (int n = 0; n < 8; n++) begin
      tick;
      chk("rr.le", 32'(le_x[0]), 32'(4'b0001 << (n % 4)));
      chk("rr.owner", 32'(owner_x[0]), 32'(n % 4));
      tick(4);
      chk("rr.le_gap", 32'(le_x[0]), 0);
    end

    // Request dropped during DRIVE does not abort
    req_x[0] = 4'b0100;
    tick;
    chk_out("drop.latch", 4'b0100, 4'b0100, 4'hF, 4'h0, 1'b1);
    tick;
    req_x[0] = 4'h0;
    chk_out("drop.d1", 4'b0100, 4'h0, 4'b1011, 4'h0, 1'b1);
    tick;
    chk_out("drop.d2", 4'b0100, 4'h0, 4'b1011, 4'b0100, 1'b1);
    tick(2);
    chk_out("drop.idle", 4'h0, 4'h0, 4'hF, 4'h0, 1'b0);

    // rr_ptr now 3: 4'b1001 must pick 3; then reset mid-DRIVE
    req_x[0] = 4'b1001;
    tick;
    chk("rr3.owner", 32'(owner_x[0]), 3);
    chk("rr3.le", 32'(le_x[0]), 32'(4'b1000));
    tick;
    chk("mid.oe_n", 32'(oe_x[0]), 32'(4'b0111));
    sys_rst = 1'b1;
    #1;
    chk_out("mid.rst", 4'h0, 4'h0, 4'hF, 4'h0, 1'b0);
    chk("mid.owner", 32'(owner_x[0]), 0);
    #2 sys_rst = 1'b0;
    tick;
    chk("post.le", 32'(le_x[0]), 32'(4'b0001));
    chk("post.owner", 32'(owner_x[0]), 0);

    // Random soak: requesters hold until latched; invariants and wait bounds per instance
    for (int k = 0; k < 3; k++) req_x[k] = 4'h0;
    for (int c = 0; c < 10000; c++) begin
      tick;
      for (int k = 0; k < 3; k++) begin
        chk_inv(k);
        for (int i = 0; i < 4; i++) begin
          if (le_x[k][i] || !req_x[k][i]) wt[k][i] = 0;
          else wt[k][i]++;
          chk("fair.wait", 32'(wt[k][i] <= bnd[k]), 1);
        end
        req_x[k] = (req_x[k] & ~le_x[k]) |
                   4'($urandom_range(0, 15) & $urandom_range(0, 15));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
